// File: rtl/pipe_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_reg_if : valid/ready stream bundle used on both sides of pipe_reg.
//   valid  producer has a word this cycle
//   data   payload, WIDTH bits
//   ready  consumer accepts the word this cycle
// master = producer side (drives valid/data), slave = consumer side.
// ---------------------------------------------------------------------------
interface pipe_reg_if #(parameter int WIDTH = 32);
   logic             valid;
   logic [WIDTH-1:0] data;
   logic             ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg : elastic pipeline register, DEPTH stages of WIDTH bits with
// valid/ready handshake, bubble collapsing, global pause and sync flush.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-high
//   pause  in   freeze all state, no transfers on either side
//   flush  in   kill every held entry at the next edge (wins over pause)
//   up     slave  stream into the block  (valid/data in, ready out)
//   dn     master stream out of the block (valid/data out, ready in)
//   count  out  entries held (stages + skid slot), $clog2(DEPTH+2) bits
//
// Build option
//   PIPE_REG_SKID_EN : adds one skid slot ahead of stage 0 so up.ready only
//   depends on registered state (no combinational path from dn.ready).
//   Capacity becomes DEPTH+1. Undefined: capacity DEPTH, up.ready is
//   combinational from dn.ready through the stage ready chain.
// ---------------------------------------------------------------------------

// One register stage. load already folds in pause and downstream readiness;
// flush clears the valid bit regardless of load.
module pipe_reg_stage #(parameter int WIDTH = 32) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             load,
   input  logic             src_v,
   input  logic [WIDTH-1:0] src_d,
   output logic             v,
   output logic [WIDTH-1:0] d
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= 1'b0;
         d <= '0;
      end else if (flush) begin
         v <= 1'b0;
      end else if (load) begin
         v <= src_v;
         // Payload only moves with a valid word; a bubble leaves d alone.
         if (src_v) d <= src_d;
      end
   end
endmodule

module pipe_reg #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 1,
   localparam int CW    = $clog2(DEPTH + 2)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pause,
   input  logic          flush,
   pipe_reg_if.slave     up,
   pipe_reg_if.master    dn,
   output logic [CW-1:0] count
);

   logic [DEPTH-1:0]            vld_pipe;
   logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
   logic [DEPTH:0]              ready;     // ready[k]: stage k may load this edge
   logic                        src0_v;
   logic [WIDTH-1:0]            src0_d;
   logic                        in_fire;
   logic                        out_fire;

   // Ready chain, evaluated from the output backwards. An empty stage is
   // always ready, which is what collapses bubbles under a stalled sink.
   always_comb begin
      ready        = '0;
      ready[DEPTH] = dn.ready & ~pause;
      for (int k = DEPTH - 1; k >= 0; k--)
         ready[k] = ~pause & (~vld_pipe[k] | ready[k + 1]);
   end

`ifdef PIPE_REG_SKID_EN
   logic             skid_v;
   logic [WIDTH-1:0] skid_d;

   // Acceptance depends only on the skid flag, so dn.ready never reaches
   // up.ready combinationally.
   assign up.ready = ~skid_v & ~pause & ~flush;

   // A parked word drains first; while parked up.ready is low, so up.data
   // can never overtake it.
   assign src0_v = skid_v | up.valid;
   assign src0_d = skid_v ? skid_d : up.data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_v <= 1'b0;
         skid_d <= '0;
      end else if (flush) begin
         skid_v <= 1'b0;
      end else if (ready[0]) begin
         // Stage 0 consumes either the parked word or the new word directly.
         skid_v <= 1'b0;
      end else if (in_fire) begin
         // Stage 0 blocked: park the accepted word.
         skid_v <= 1'b1;
         skid_d <= up.data;
      end
   end
`else
   assign up.ready = ready[0] & ~flush;
   assign src0_v   = up.valid;
   assign src0_d   = up.data;
`endif

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .load  (ready[g]),
            .src_v (src0_v),
            .src_d (src0_d),
            .v     (vld_pipe[g]),
            .d     (dat_pipe[g])
         );
      end else begin : g_body
         pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .load  (ready[g]),
            .src_v (vld_pipe[g-1]),
            .src_d (dat_pipe[g-1]),
            .v     (vld_pipe[g]),
            .d     (dat_pipe[g])
         );
      end
   end

   // Output is hidden during pause but the held word stays in place.
   assign dn.valid = vld_pipe[DEPTH-1] & ~pause;
   assign dn.data  = dat_pipe[DEPTH-1];

   assign in_fire  = up.valid & up.ready;
   assign out_fire = dn.valid & dn.ready;

   // Occupancy: flush empties everything, including any word leaving in
   // the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (in_fire && !out_fire) begin
         count <= count + CW'(1);
      end else if (!in_fire && out_fire) begin
         count <= count - CW'(1);
      end
   end

endmodule
